// File: rtl/dff_reset_en.sv
// Resettable, load-enabled D register; the basic gated storage primitive.
// Reset is synchronous and takes priority over the load enable.
module dff_reset_en #(
  parameter int unsigned         WIDTH       = 1,
  parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Enable is a data-path hold rather than a gated clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff_reset_en.sv
// Directed bench for dff_reset_en: a default 1-bit instance and an 8-bit
// instance with a non-zero reset value.
module tb_dff_reset_en;

  logic       clk;
  logic       reset, en, d;
  logic       q;
  logic       w_reset, w_en;
  logic [7:0] w_d, w_q;

  int n_cmp = 0;
  int n_bad = 0;

  dff_reset_en u_bit (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q)
  );

  dff_reset_en #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_byte (
    .clk   (clk),
    .reset (w_reset),
    .en    (w_en),
    .d     (w_d),
    .q     (w_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; d = 1'b0;
    w_reset = 1'b0; w_en = 1'b0; w_d = 8'h00;
    #1;

    // Reset
    reset = 1'b1; en = 1'b0; d = 1'b0;
    tick();
    check("reset", {7'b0, q}, 8'h00);

    // Load: no change before the edge, new value after
    reset = 1'b0; en = 1'b1; d = 1'b1;
    #1;
    check("load_pre_edge", {7'b0, q}, 8'h00);
    tick();
    check("load", {7'b0, q}, 8'h01);

    // Hold with d toggling
    en = 1'b0;
    d = 1'b0; tick(); check("hold0", {7'b0, q}, 8'h01);
    d = 1'b1; tick(); check("hold1", {7'b0, q}, 8'h01);
    d = 1'b0; tick(); check("hold2", {7'b0, q}, 8'h01);

    // Reset beats enable, then loading resumes
    reset = 1'b1; en = 1'b1; d = 1'b1;
    tick();
    check("prio_reset", {7'b0, q}, 8'h00);
    reset = 1'b0;
    tick();
    check("prio_release", {7'b0, q}, 8'h01);

    // Reset pulse confined to clk-low must not touch q
    en = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    check("sync_pulse_now", {7'b0, q}, 8'h01);
    tick();
    check("sync_pulse_edge", {7'b0, q}, 8'h01);
    reset = 1'b1;
    tick();
    check("sync_held", {7'b0, q}, 8'h00);
    reset = 1'b0;

    // 8-bit instance with RESET_VALUE = 8'hA5
    w_reset = 1'b1;
    tick();
    check("w_reset", w_q, 8'hA5);
    w_reset = 1'b0; w_en = 1'b1; w_d = 8'h3C;
    tick();
    check("w_load", w_q, 8'h3C);
    w_en = 1'b0; w_d = 8'hFF;
    tick();
    check("w_hold", w_q, 8'h3C);
    w_en = 1'b1; w_d = 8'h5A;
    tick();
    check("w_load2", w_q, 8'h5A);
    w_reset = 1'b1; w_d = 8'hC3;
    tick();
    check("w_prio_reset", w_q, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
